// File: rtl/cen_mean_controller.sv
// cen_mean_controller
// Sequences the centering stage of the whitening front end. It accumulates
// 2^LOG2_N samples on each of four signed channels, pulses the shared CEN
// divider (registered 1-cycle arithmetic shift by LOG2_N) once, captures the
// four means and offers them downstream with a valid/ready handshake.
//
// Optional feature: define CEN_ROUND_EN to add 2^(LOG2_N-1) to each divider
// input. This turns the divider's floor division into round-half-up division.
// The state machine and the latency are the same with or without it.
module cen_mean_controller #(
  parameter int SAMPLE_W     = 14,
  parameter int LOG2_N       = 7,
  parameter int SUM_W        = 21,
  parameter int RES_W        = 16,
  parameter int AUTO_RESTART = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_ch1,
  input  logic [SAMPLE_W-1:0] s_ch2,
  input  logic [SAMPLE_W-1:0] s_ch3,
  input  logic [SAMPLE_W-1:0] s_ch4,
  output logic                div_en,
  output logic [SUM_W-1:0]    div_sum1,
  output logic [SUM_W-1:0]    div_sum2,
  output logic [SUM_W-1:0]    div_sum3,
  output logic [SUM_W-1:0]    div_sum4,
  input  logic [RES_W-1:0]    div_res1,
  input  logic [RES_W-1:0]    div_res2,
  input  logic [RES_W-1:0]    div_res3,
  input  logic [RES_W-1:0]    div_res4,
  output logic                mean_valid,
  input  logic                mean_ready,
  output logic [RES_W-1:0]    mean1,
  output logic [RES_W-1:0]    mean2,
  output logic [RES_W-1:0]    mean3,
  output logic [RES_W-1:0]    mean4,
  output logic                busy,
  output logic [LOG2_N-1:0]   sample_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DIVIDE = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t state, next_state;

  logic [SAMPLE_W-1:0] smp [4];
  logic [SUM_W-1:0]    acc [4];
  logic [RES_W-1:0]    res [4];
  logic [RES_W-1:0]    mean_q [4];
  logic [SUM_W-1:0]    sum [4];

  logic accept;
  logic clear;

  assign smp[0] = s_ch1;
  assign smp[1] = s_ch2;
  assign smp[2] = s_ch3;
  assign smp[3] = s_ch4;

  assign res[0] = div_res1;
  assign res[1] = div_res2;
  assign res[2] = div_res3;
  assign res[3] = div_res4;

  // A sample is taken only while in ACCUM; sums restart on every entry to ACCUM.
  assign accept = (state == ACCUM) && s_valid;
  assign clear  = (state != ACCUM) && (next_state == ACCUM);

`ifdef CEN_ROUND_EN
  // Half an LSB of the quotient, so the shift rounds half-up instead of flooring.
  localparam int ROUND_BIAS = 1 << (LOG2_N - 1);
  assign sum[0] = acc[0] + SUM_W'(ROUND_BIAS);
  assign sum[1] = acc[1] + SUM_W'(ROUND_BIAS);
  assign sum[2] = acc[2] + SUM_W'(ROUND_BIAS);
  assign sum[3] = acc[3] + SUM_W'(ROUND_BIAS);
`else
  assign sum[0] = acc[0];
  assign sum[1] = acc[1];
  assign sum[2] = acc[2];
  assign sum[3] = acc[3];
`endif

  assign div_sum1 = sum[0];
  assign div_sum2 = sum[1];
  assign div_sum3 = sum[2];
  assign div_sum4 = sum[3];

  assign mean1 = mean_q[0];
  assign mean2 = mean_q[1];
  assign mean3 = mean_q[2];
  assign mean4 = mean_q[3];

  // State register; reset abandons any block in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus the state-decoded strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    next_state = state;
    s_ready    = 1'b0;
    div_en     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) next_state = ACCUM;
      end
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && (sample_cnt == '1)) next_state = DIVIDE;
      end
      DIVIDE: begin
        div_en     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (mean_valid && mean_ready)
          next_state = (AUTO_RESTART != 0) ? ACCUM : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-channel accumulators and the accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      sample_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++)
        acc[i] <= acc[i] + {{(SUM_W-SAMPLE_W){smp[i][SAMPLE_W-1]}}, smp[i]};
      // Wraps to zero on the last sample of the block.
      sample_cnt <= sample_cnt + LOG2_N'(1);
    end
  end

  // Capture divider results in WAIT and hold them until downstream accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mean_q[i] <= '0;
      mean_valid <= 1'b0;
    end else if (state == WAIT) begin
      for (int i = 0; i < 4; i++) mean_q[i] <= res[i];
      mean_valid <= 1'b1;
    end else if ((state == HOLD) && mean_ready) begin
      mean_valid <= 1'b0;
    end
  end

endmodule
